mem_d_arbiter: RTL and testbench
================================

// Module: mem_d_arbiter
// PURPOSE
//  Two-master arbiter for the data port (port 2) of dual_port_mem. Master 0 is the riscv
//  data bus; master 1 is a secondary requester (debug loader / DMA). It uses a round-robin
//  policy with optional locked bursts. One memory access per cycle. Read data returns
//  registered, one cycle after grant. It sits between the masters and the memory-address
//  switcher in top.
// PARAMETERS
//  DATA_W     32  data width (matches `MEM_DATA_BUS)
//  ADDR_W     32  address width (matches `MEM_ADDR_BUS)
//  MASK_W     4   byte write-mask width (matches `MEM_WMASK_BUS)
//  MAX_BURST  4   max consecutive locked grants to one master; range 1..255; 1 = lock ignored
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-low reset
//  mN_req       in   1       master N (N=0,1) request; a/we/wd/wmask held stable until gnt
//  mN_lock      in   1       master N asks to keep ownership after this beat
//  mN_a         in   ADDR_W  address
//  mN_we        in   1       write enable
//  mN_wd        in   DATA_W  write data
//  mN_wmask     in   MASK_W  byte write mask
//  mN_gnt       out  1       beat accepted this cycle (combinational from req/state)
//  mN_rvalid    out  1       rd valid: one cycle after a granted read beat
//  mN_rd        out  DATA_W  registered read data
//  mem_a        out  ADDR_W  to dual_port_mem a2
//  mem_we       out  1       to we2
//  mem_wd       out  DATA_W  to wd2
//  mem_wmask    out  MASK_W  to w2mask
//  mem_rd       in   DATA_W  from rd2 (combinational read)
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE, last_grant=1 (so master 0 wins first), burst_cnt=0,
//    mN_rvalid=0, mN_rd=0. All mem_* outputs are 0 and every gnt is 0 while reset is low.
//  - FSM states: IDLE, OWN0, OWN1. OWNx means master x holds a locked burst.
//  - IDLE: grant goes to the only requester. If both request, the master != last_grant wins.
//    The winner's fields drive mem_* in the same cycle and gnt=1; last_grant <= winner.
//    Winner lock=1 and MAX_BURST>1 -> OWNwinner, burst_cnt <= 1.
//  - OWNx: master x is granted whenever req_x=1, regardless of the other master.
//    Each grant increments burst_cnt.
//  - OWNx exits to IDLE (arbitration resumes next cycle) on any of:
//    req_x=0; lock_x=0 on a granted beat; burst_cnt reaches MAX_BURST with the other master
//    requesting. If the other master is not requesting at the cap, burst_cnt saturates and
//    ownership holds.
//  - No grant in a cycle: mem_we=0, mem_a=0, mem_wd=0, mem_wmask=0. The idle bus never writes.
//  - Granted read (we=0): mem_rd is sampled at the clock edge. The next cycle has
//    mN_rvalid=1 and mN_rd=sample. rvalid is a 1-cycle pulse. mN_rd holds its value until
//    the next read.
//  - Granted write: no rvalid. Back-to-back reads give a continuous rvalid stream, one per beat.
//  - Throughput: 1 beat/cycle total. Latency: write 0 cycles (gnt cycle); read 1 cycle.
//  - Simultaneous unlocked requests: grants alternate 0,1,0,1...
//  - A req dropped without gnt is legal and has no side effect.
//  - Reset mid-burst: ownership and any pending rvalid are discarded. No spurious rvalid
//    after reset release.
//  - burst_cnt is 8 bits; it never wraps (saturates at MAX_BURST).
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs stat_gnt0, stat_gnt1, stat_conflict (32 bits each):
//    - grant count per master
//    - count of cycles where both req=1 and one master was denied
//    All wrap mod 2^32, clear on reset, increment in the cycle the event occurs.
//  ARB_STATS_EN undefined: these ports and counters do not exist; arbitration is unchanged.
// TESTING
//  1. Only m0 reads a=0x40, mem holds 0xDEADBEEF at 0x40 -> m0_gnt same cycle;
//     next cycle m0_rvalid=1, m0_rd=0xDEADBEEF.
//  2. m0,m1 both req unlocked writes for 6 cycles -> gnt order 0,1,0,1,0,1;
//     mem_we=1 each cycle.
//  3. MAX_BURST=4, m1 lock=1 for 6 beats, m0 req continuous -> m1 gets 4 beats,
//     then m0 gets 1 beat, then m1 resumes.
//  4. m1 locked with m0 idle -> m1 keeps ownership past 4 beats; m0 req arriving
//     at burst_cnt=4 is granted the next cycle.
//  5. Assert reset low during an OWN0 read beat -> all mem_* and rvalid are 0 immediately;
//     after release m0 wins the first contended grant.
//  6. ARB_STATS_EN, test 2 stimulus -> stat_gnt0=3, stat_gnt1=3, stat_conflict=6.

Source files
------------

// File: rtl/mem_d_arbiter.sv
// Two-master round-robin arbiter with optional locked bursts for the dual_port_mem data port.
// Optional statistics counters are compiled in with `define ARB_STATS_EN.
module mem_d_arbiter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MASK_W    = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_a,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_wd,
    input  logic [MASK_W-1:0] m0_wmask,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rd,

    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_a,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_wd,
    input  logic [MASK_W-1:0] m1_wmask,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rd,

    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    output logic [MASK_W-1:0] mem_wmask,
`ifdef ARB_STATS_EN
    output logic [31:0]       stat_gnt0,
    output logic [31:0]       stat_gnt1,
    output logic [31:0]       stat_conflict,
`endif
    input  logic [DATA_W-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam logic [7:0] BURST_CAP = 8'(MAX_BURST);
    localparam bit         LOCK_EN   = (MAX_BURST > 1);

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [7:0]          burst_cnt_q, burst_cnt_d;
    logic [7:0]          cnt_inc;
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]   rd0_q, rd0_d;
    logic [DATA_W-1:0]   rd1_q, rd1_d;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        m0_gnt       = 1'b0;
        m1_gnt       = 1'b0;
        cnt_inc      = (burst_cnt_q >= BURST_CAP) ? burst_cnt_q : burst_cnt_q + 8'd1;

        unique case (state_q)
            IDLE: begin
                // last_grant_q == 1 means master 0 has priority on a tie
                if (m0_req && (!m1_req || last_grant_q)) begin
                    m0_gnt       = 1'b1;
                    last_grant_d = 1'b0;
                    if (m0_lock && LOCK_EN) begin
                        state_d     = OWN0;
                        burst_cnt_d = 8'd1;
                    end
                end else if (m1_req) begin
                    m1_gnt       = 1'b1;
                    last_grant_d = 1'b1;
                    if (m1_lock && LOCK_EN) begin
                        state_d     = OWN1;
                        burst_cnt_d = 8'd1;
                    end
                end
            end
            OWN0: begin
                if (!m0_req) begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end else begin
                    m0_gnt       = 1'b1;
                    last_grant_d = 1'b0;
                    burst_cnt_d  = cnt_inc;
                    if (!m0_lock || (cnt_inc == BURST_CAP && m1_req)) begin
                        state_d     = IDLE;
                        burst_cnt_d = '0;
                    end
                end
            end
            OWN1: begin
                if (!m1_req) begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end else begin
                    m1_gnt       = 1'b1;
                    last_grant_d = 1'b1;
                    burst_cnt_d  = cnt_inc;
                    if (!m1_lock || (cnt_inc == BURST_CAP && m0_req)) begin
                        state_d     = IDLE;
                        burst_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase

        // Grants are combinational, so they must be forced off while reset is held
        if (!reset) begin
            m0_gnt = 1'b0;
            m1_gnt = 1'b0;
        end
    end

    always_comb begin
        mem_a     = '0;
        mem_we    = 1'b0;
        mem_wd    = '0;
        mem_wmask = '0;
        if (m0_gnt) begin
            mem_a     = m0_a;
            mem_we    = m0_we;
            mem_wd    = m0_wd;
            mem_wmask = m0_wmask;
        end else if (m1_gnt) begin
            mem_a     = m1_a;
            mem_we    = m1_we;
            mem_wd    = m1_wd;
            mem_wmask = m1_wmask;
        end
    end

    always_comb begin
        rvalid0_d = m0_gnt && !m0_we;
        rvalid1_d = m1_gnt && !m1_we;
        rd0_d     = rvalid0_d ? mem_rd : rd0_q;
        rd1_d     = rvalid1_d ? mem_rd : rd1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            burst_cnt_q  <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rd0_q        <= '0;
            rd1_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
        end
    end

    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    assign m0_rd     = rd0_q;
    assign m1_rd     = rd1_q;

`ifdef ARB_STATS_EN
    logic [31:0] stat_gnt0_q, stat_gnt0_d;
    logic [31:0] stat_gnt1_q, stat_gnt1_d;
    logic [31:0] stat_conflict_q, stat_conflict_d;

    always_comb begin
        stat_gnt0_d     = stat_gnt0_q + {31'd0, m0_gnt};
        stat_gnt1_d     = stat_gnt1_q + {31'd0, m1_gnt};
        stat_conflict_d = stat_conflict_q + {31'd0, (m0_req && m1_req && (m0_gnt ^ m1_gnt))};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_gnt0_q     <= '0;
            stat_gnt1_q     <= '0;
            stat_conflict_q <= '0;
        end else begin
            stat_gnt0_q     <= stat_gnt0_d;
            stat_gnt1_q     <= stat_gnt1_d;
            stat_conflict_q <= stat_conflict_d;
        end
    end

    assign stat_gnt0     = stat_gnt0_q;
    assign stat_gnt1     = stat_gnt1_q;
    assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_mem_d_arbiter.sv
// Self-checking bench for mem_d_arbiter: directed scenarios plus random traffic against
// a behavioural ownership/round-robin model and a small memory array.
module tb_mem_d_arbiter;

    localparam int MB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [1:0]  rq = '0, lk = '0, we = '0;
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [3:0]  wm [2];

    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rd, m1_rd;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;
    logic [3:0]  mem_wmask;
`ifdef ARB_STATS_EN
    logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

    mem_d_arbiter #(
        .DATA_W(32), .ADDR_W(32), .MASK_W(4), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_req(rq[0]), .m0_lock(lk[0]), .m0_a(ad[0]), .m0_we(we[0]),
        .m0_wd(wd[0]), .m0_wmask(wm[0]), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rd(m0_rd),
        .m1_req(rq[1]), .m1_lock(lk[1]), .m1_a(ad[1]), .m1_we(we[1]),
        .m1_wd(wd[1]), .m1_wmask(wm[1]), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rd(m1_rd),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_wmask(mem_wmask),
`ifdef ARB_STATS_EN
        .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict),
`endif
        .mem_rd(mem_rd)
    );

    // Memory stand-in: combinational read, masked write on the clock edge
    logic [31:0] mem [64];
    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem[mem_a[7:2]][8*b +: 8] <= mem_wd[8*b +: 8];
        end
    end

    int unsigned n_vec = 0, n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner (-1 = none), beats in current run, last winner
    int          own = -1, run = 0, last = 1, mg = -1, gi = 0;
    logic [1:0]  exp_rv = '0;
    logic [31:0] exp_rd [2];
    int unsigned c_g0 = 0, c_g1 = 0, c_cf = 0;

    task automatic cyc_check();
        #1;
        if (own >= 0)          mg = rq[own] ? own : -1;
        else if (rq == 2'b11)  mg = 1 - last;
        else if (rq[0])        mg = 0;
        else if (rq[1])        mg = 1;
        else                   mg = -1;
        gi = (mg < 0) ? 0 : mg;
        check("gnt0", m0_gnt, mg == 0);
        check("gnt1", m1_gnt, mg == 1);
        check("mem_a", mem_a, (mg >= 0) ? ad[gi] : 32'h0);
        check("mem_we", mem_we, (mg >= 0) ? we[gi] : 1'b0);
        check("mem_wd", mem_wd, (mg >= 0) ? wd[gi] : 32'h0);
        check("mem_wmask", mem_wmask, (mg >= 0) ? wm[gi] : 4'h0);
        check("rvalid0", m0_rvalid, exp_rv[0]);
        check("rvalid1", m1_rvalid, exp_rv[1]);
        check("rd0", m0_rd, exp_rd[0]);
        check("rd1", m1_rd, exp_rd[1]);
`ifdef ARB_STATS_EN
        check("stat_gnt0", stat_gnt0, c_g0);
        check("stat_gnt1", stat_gnt1, c_g1);
        check("stat_conflict", stat_conflict, c_cf);
`endif
    endtask

    task automatic cyc_end();
        logic [1:0] nrv;
        nrv = '0;
        if (mg >= 0 && !we[gi]) begin
            nrv[gi]    = 1'b1;
            exp_rd[gi] = mem[ad[gi][7:2]];
        end
        if (mg == 0) c_g0++;
        if (mg == 1) c_g1++;
        if (rq == 2'b11) c_cf++;
        if (own >= 0) begin
            if (!rq[own]) own = -1;
            else begin
                run = (run + 1 > MB) ? MB : run + 1;
                if (!lk[own] || (run == MB && rq[1-own])) own = -1;
            end
        end else if (mg >= 0) begin
            last = mg;
            if (lk[mg] && MB > 1) begin
                own = mg;
                run = 1;
            end
        end
        exp_rv = nrv;
        @(negedge clk);
    endtask

    task automatic step();
        cyc_check();
        cyc_end();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once
    task automatic apply_reset();
        reset = 1'b0;
        #1;
        check("rst_gnt0", m0_gnt, 1'b0);
        check("rst_gnt1", m1_gnt, 1'b0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_wd", mem_wd, 32'h0);
        check("rst_mem_wmask", mem_wmask, 4'h0);
        check("rst_rvalid0", m0_rvalid, 1'b0);
        check("rst_rvalid1", m1_rvalid, 1'b0);
        check("rst_rd0", m0_rd, 32'h0);
        check("rst_rd1", m1_rd, 32'h0);
        own = -1; run = 0; last = 1; mg = -1;
        exp_rv = '0; exp_rd[0] = '0; exp_rd[1] = '0;
        c_g0 = 0; c_g1 = 0; c_cf = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Pending requests keep their fields until granted (sometimes withdrawn)
    task automatic rand_inputs();
        for (int m = 0; m < 2; m++) begin
            if (!(rq[m] && mg != m && $urandom_range(7) != 0)) begin
                rq[m] = ($urandom_range(3) != 0);
                we[m] = $urandom_range(1);
                ad[m] = $urandom;
                wd[m] = $urandom;
                wm[m] = 4'($urandom_range(15));
            end
            lk[m] = ($urandom_range(3) != 0);
        end
    endtask

    initial begin
        int n, b1;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[16] = 32'hDEADBEEF;
        for (int m = 0; m < 2; m++) begin
            ad[m] = '0; wd[m] = '0; wm[m] = '0; exp_rd[m] = '0;
        end
        #1;
        apply_reset();

        // Single read from m0
        rq = 2'b01; we = 2'b00; lk = 2'b00; ad[0] = 32'h40;
        step();
        rq = 2'b00;
        check("t1_rvalid", m0_rvalid, 1'b1);
        check("t1_rd", m0_rd, 32'hDEADBEEF);
        step();
        step();

        // Contended unlocked writes alternate starting with m0
        apply_reset();
        rq = 2'b11; we = 2'b11; lk = 2'b00;
        ad[0] = 32'h10; wd[0] = 32'h1111_0000; wm[0] = 4'hF;
        ad[1] = 32'h20; wd[1] = 32'h2222_0000; wm[1] = 4'h3;
        for (int i = 0; i < 6; i++) begin
            cyc_check();
            check("t2_gnt0", m0_gnt, (i % 2) == 0);
            check("t2_we", mem_we, 1'b1);
            cyc_end();
        end
        rq = 2'b00;
`ifdef ARB_STATS_EN
        check("t6_gnt0", stat_gnt0, 32'd3);
        check("t6_gnt1", stat_gnt1, 32'd3);
        check("t6_conflict", stat_conflict, 32'd6);
`endif
        step();

        // m1 locked burst capped at MB while m0 waits
        apply_reset();
        rq = 2'b10; lk = 2'b10; we = 2'b10;
        ad[0] = 32'h44; ad[1] = 32'h48; wd[1] = 32'hCAFE_F00D; wm[1] = 4'hF;
        n = 0; b1 = 0;
        while (b1 < 6 && n < 40) begin
            if (n == 1) rq[0] = 1'b1;
            cyc_check();
            if (n <= 6) begin
                check("t3_gnt0", m0_gnt, n == 4);
                check("t3_gnt1", m1_gnt, n != 4);
            end
            if (mg == 1) b1++;
            cyc_end();
            n++;
        end
        check("t3_beats", b1, 6);
        rq[1] = 1'b0; lk = 2'b00;
        step();
        step();
        rq = 2'b00;
        step();

        // m1 lock holds past the cap until m0 shows up
        apply_reset();
        rq = 2'b10; lk = 2'b10; we = 2'b10;
        for (int i = 0; i < 6; i++) step();
        rq[0] = 1'b1; we[0] = 1'b1; ad[0] = 32'h4C; wd[0] = 32'h0BAD_F00D; wm[0] = 4'hC;
        cyc_check();
        check("t4_hold_gnt1", m1_gnt, 1'b1);
        check("t4_wait_gnt0", m0_gnt, 1'b0);
        cyc_end();
        cyc_check();
        check("t4_next_gnt0", m0_gnt, 1'b1);
        cyc_end();
        rq = 2'b00; lk = 2'b00;
        step();

        // Reset asserted during an OWN0 read beat
        apply_reset();
        rq = 2'b01; lk = 2'b01; we = 2'b00; ad[0] = 32'h40;
        step();
        cyc_check();
        apply_reset();
        rq = 2'b11; lk = 2'b00; we = 2'b00;
        cyc_check();
        check("t5_first_gnt0", m0_gnt, 1'b1);
        cyc_end();
        rq = 2'b00;
        step();
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) apply_reset();
            rand_inputs();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
